// File: rtl/mimc_round_ctrl.sv
// mimc_round_ctrl: MiMC-x^3 round sequencer over the BN254 scalar field, feeding an external cube core and reading a round-constant ROM.
// Latency: N_ROUNDS*(2+L)+2 cycles from the accepted start edge to done, where L is the cube-core latency.
// Backpressure: waits indefinitely on pow_done; start is only accepted in IDLE and never on the done cycle.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   start, msg, key  job request; msg/key latched when start is accepted
//   busy, done, hash job status and result (hash held until the next accepted start)
//   rc_addr, rc_data round-constant ROM address (registered) and data (valid one cycle later)
//   pow_en, pow_base cube-core enable and base (both registered)
//   pow_result, pow_done cube-core result and completion
module mimc_round_ctrl #(
    parameter int                N_BITS   = 254,
    parameter int                N_ROUNDS = 91,
    parameter logic [N_BITS-1:0] PRIME    = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    // A single-round build still needs a one-bit address port.
    parameter int                RC_AW    = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] msg,
    input  logic [N_BITS-1:0] key,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] hash,
    output logic [RC_AW-1:0]  rc_addr,
    input  logic [N_BITS-1:0] rc_data,
    output logic              pow_en,
    output logic [N_BITS-1:0] pow_base,
    input  logic [N_BITS-1:0] pow_result,
    input  logic              pow_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ADD,
        S_WAIT_POW,
        S_FINAL
    } state_t;

    localparam logic [RC_AW-1:0] LAST_ROUND = RC_AW'(N_ROUNDS - 1);

    state_t              state_q,    state_d;
    logic [N_BITS-1:0]   x_q,        x_d;
    logic [N_BITS-1:0]   k_q,        k_d;
    logic [RC_AW-1:0]    round_q,    round_d;
    logic [RC_AW-1:0]    rc_addr_q,  rc_addr_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [N_BITS-1:0]   hash_q,     hash_d;
    logic                pow_en_q,   pow_en_d;
    logic [N_BITS-1:0]   pow_base_q, pow_base_d;

    logic [N_BITS-1:0]   sum_xk;
    logic [N_BITS-1:0]   sum_xkc;

    // Operands are assumed reduced, so one conditional subtract suffices.
    function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a,
                                                  input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME}) begin
            s = s - {1'b0, PRIME};
        end
        return s[N_BITS-1:0];
    endfunction

    // Both adds chained in one cycle; sum_xk is also the final hash.
    assign sum_xk  = mod_add(x_q, k_q);
    assign sum_xkc = mod_add(sum_xk, rc_data);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        k_d        = k_q;
        round_d    = round_q;
        rc_addr_d  = rc_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hash_d     = hash_q;
        pow_en_d   = pow_en_q;
        pow_base_d = pow_base_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d   = 1'b0;
                pow_en_d = 1'b0;
                // The done cycle is spent in IDLE; a start there is dropped.
                if (start && !done_q) begin
                    x_d       = msg;
                    k_d       = key;
                    round_d   = '0;
                    rc_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                // Guaranteed low cycle on pow_en so the core restarts cleanly.
                pow_en_d = 1'b0;
                state_d  = S_ADD;
            end
            S_ADD: begin
                pow_base_d = sum_xkc;
                pow_en_d   = 1'b1;
                state_d    = S_WAIT_POW;
            end
            S_WAIT_POW: begin
                if (pow_done) begin
                    x_d      = pow_result;
                    pow_en_d = 1'b0;
                    if (round_q == LAST_ROUND) begin
                        state_d = S_FINAL;
                    end else begin
                        round_d   = round_q + 1'b1;
                        rc_addr_d = round_q + 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_FINAL: begin
                // busy stays up through the done cycle and drops in IDLE.
                hash_d  = sum_xk;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            k_q        <= '0;
            round_q    <= '0;
            rc_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hash_q     <= '0;
            pow_en_q   <= 1'b0;
            pow_base_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            k_q        <= k_d;
            round_q    <= round_d;
            rc_addr_q  <= rc_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hash_q     <= hash_d;
            pow_en_q   <= pow_en_d;
            pow_base_q <= pow_base_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hash     = hash_q;
    assign rc_addr  = rc_addr_q;
    assign pow_en   = pow_en_q;
    assign pow_base = pow_base_q;

endmodule

// File: tb/tb_mimc_round_ctrl.sv
// tb_mimc_round_ctrl: bench for the MiMC-x^3 round sequencer with 2-round, 1-round and 91-round instances.
// Each instance has its own registered ROM and a behavioural cube core with programmable latency.
// Random 91-round jobs are compared against a big-integer MiMC model; spurious pow_done pulses are injected.
module tb_mimc_round_ctrl;

    localparam logic [253:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [253:0] msg = '0;
    logic [253:0] key = '0;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- field helpers (plain big-integer arithmetic) ----------------
    function automatic logic [253:0] fmul(input logic [253:0] a, input logic [253:0] b);
        logic [507:0] w;
        w = {254'b0, a} * {254'b0, b};
        w = w % {254'b0, P};
        return w[253:0];
    endfunction

    function automatic logic [253:0] fcube(input logic [253:0] a);
        return fmul(fmul(a, a), a);
    endfunction

    function automatic logic [253:0] rand_fe();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        r = r % {2'b0, P};
        return r[253:0];
    endfunction

    // ---------------- 2-round instance ----------------
    logic         start2 = 1'b0;
    logic         busy2, done2, pow_en2, pow_done2, rc_addr2;
    logic [253:0] hash2, pow_base2, pow_result2;
    logic [253:0] rc_data2 = '0;
    logic [253:0] rom2 [0:1];
    int           cnt2 = 0;
    int           lat2 = 5;

    mimc_round_ctrl #(.N_ROUNDS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .msg(msg), .key(key),
        .busy(busy2), .done(done2), .hash(hash2),
        .rc_addr(rc_addr2), .rc_data(rc_data2),
        .pow_en(pow_en2), .pow_base(pow_base2), .pow_result(pow_result2), .pow_done(pow_done2)
    );

    always @(posedge clk) rc_data2 <= rom2[rc_addr2];
    always @(posedge clk or negedge rst)
        if (!rst) cnt2 <= 0;
        else      cnt2 <= (pow_en2 && !pow_done2) ? cnt2 + 1 : 0;
    assign pow_done2   = pow_en2 && (cnt2 == lat2 - 1);
    assign pow_result2 = fcube(pow_base2);

    // ---------------- 1-round instance ----------------
    logic         start1 = 1'b0;
    logic         busy1, done1, pow_en1, pow_done1, rc_addr1;
    logic [253:0] hash1, pow_base1, pow_result1;
    logic [253:0] rc_data1 = '0;
    logic [253:0] rom1 = '0;
    int           cnt1 = 0;
    int           lat1 = 3;

    mimc_round_ctrl #(.N_ROUNDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .msg(msg), .key(key),
        .busy(busy1), .done(done1), .hash(hash1),
        .rc_addr(rc_addr1), .rc_data(rc_data1),
        .pow_en(pow_en1), .pow_base(pow_base1), .pow_result(pow_result1), .pow_done(pow_done1)
    );

    always @(posedge clk) rc_data1 <= (rc_addr1 == 1'b0) ? rom1 : '0;
    always @(posedge clk or negedge rst)
        if (!rst) cnt1 <= 0;
        else      cnt1 <= (pow_en1 && !pow_done1) ? cnt1 + 1 : 0;
    assign pow_done1   = pow_en1 && (cnt1 == lat1 - 1);
    assign pow_result1 = fcube(pow_base1);

    // ---------------- 91-round (default) instance ----------------
    logic         start91 = 1'b0;
    logic         busy91, done91, pow_en91, pow_done91;
    logic [6:0]   rc_addr91;
    logic [253:0] hash91, pow_base91, pow_result91;
    logic [253:0] rc_data91 = '0;
    logic [253:0] rom91 [0:90];
    int           cnt91 = 0;
    int           lat91 = 1;
    logic         spur91 = 1'b0;

    mimc_round_ctrl u_dut91 (
        .clk(clk), .rst(rst), .start(start91), .msg(msg), .key(key),
        .busy(busy91), .done(done91), .hash(hash91),
        .rc_addr(rc_addr91), .rc_data(rc_data91),
        .pow_en(pow_en91), .pow_base(pow_base91), .pow_result(pow_result91), .pow_done(pow_done91)
    );

    always @(posedge clk) rc_data91 <= (rc_addr91 <= 7'd90) ? rom91[rc_addr91] : '0;
    always @(posedge clk or negedge rst)
        if (!rst) cnt91 <= 0;
        else      cnt91 <= (pow_en91 && !pow_done91) ? cnt91 + 1 : 0;
    // Stray completions while the core is idle must be ignored by the sequencer.
    always @(negedge clk) spur91 <= ($urandom_range(0, 2) == 0);
    assign pow_done91   = (pow_en91 && (cnt91 == lat91 - 1)) || (!pow_en91 && spur91);
    assign pow_result91 = fcube(pow_base91);

    // ---------------- monitors (sampled on the falling edge) ----------------
    logic [253:0] bq2[$], bq1[$], bq91[$];
    logic         pe2_prev = 1'b0, pe1_prev = 1'b0, pe91_prev = 1'b0;
    int           ndone2 = 0;
    int           addr_err91 = 0;
    int           base91 = 0;

    always @(negedge clk) begin
        if (pow_en2 && !pe2_prev) bq2.push_back(pow_base2);
        if (pow_en1 && !pe1_prev) bq1.push_back(pow_base1);
        if (pow_en91 && !pe91_prev) begin
            // The address seen at each cube launch must equal that job's round index.
            if (int'(rc_addr91) != bq91.size() - base91) addr_err91 <= addr_err91 + 1;
            bq91.push_back(pow_base91);
        end
        if (busy91 && rc_addr91 > 7'd90) addr_err91 <= addr_err91 + 1;
        if (done2) ndone2 <= ndone2 + 1;
        pe2_prev  <= pow_en2;
        pe1_prev  <= pow_en1;
        pe91_prev <= pow_en91;
    end

    // ---------------- checking and sequencing ----------------
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_done(input int w);
        case (w)
            0:       return done2;
            1:       return done1;
            default: return done91;
        endcase
    endfunction

    function automatic logic sel_busy(input int w);
        case (w)
            0:       return busy2;
            1:       return busy1;
            default: return busy91;
        endcase
    endfunction

    // Returns at the falling edge of cycle 1 (first cycle after the start edge).
    task automatic pulse_start(input int w, input logic [253:0] m, input logic [253:0] k);
        @(negedge clk);
        msg = m;
        key = k;
        case (w)
            0:       start2  = 1'b1;
            1:       start1  = 1'b1;
            default: start91 = 1'b1;
        endcase
        @(negedge clk);
        start2  = 1'b0;
        start1  = 1'b0;
        start91 = 1'b0;
    endtask

    // dcyc = cycle index of done relative to the start edge; 0 if the budget ran out.
    task automatic wait_done(input int w, input int budget, output int dcyc, output int busy_bad);
        dcyc     = 0;
        busy_bad = 0;
        for (int c = 1; c <= budget; c++) begin
            if (!sel_busy(w)) busy_bad++;
            if (sel_done(w)) begin
                dcyc = c;
                break;
            end
            @(negedge clk);
        end
        if (dcyc == 0) $display("FAIL wait_done[%0d]: no done within %0d cycles", w, budget);
    endtask

    logic [253:0] exp_base [0:90];

    task automatic model(input logic [253:0] m, input logic [253:0] k,
                         input logic [253:0] rc [0:90], output logic [253:0] h);
        logic [253:0] x;
        logic [255:0] s;
        x = m;
        for (int i = 0; i < 91; i++) begin
            s = ({2'b0, x} + {2'b0, k} + {2'b0, rc[i]}) % {2'b0, P};
            exp_base[i] = s[253:0];
            x = fcube(s[253:0]);
        end
        s = ({2'b0, x} + {2'b0, k}) % {2'b0, P};
        h = s[253:0];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc, bb, b0, nd0, berr, n0;
        logic [253:0] m, k, h_exp;

        rom2[0] = '0;
        rom2[1] = 254'd3;
        for (int i = 0; i < 91; i++) rom91[i] = rand_fe();

        repeat (3) @(negedge clk);
        chk("rst_pow_en2_in_reset", pow_en2, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy2", busy2, 0);
        chk("rst_done2", done2, 0);
        chk("rst_hash2", hash2, 0);
        chk("rst_rc_addr2", rc_addr2, 0);
        chk("rst_pow_base91", pow_base91, 0);
        chk("rst_busy91", busy91, 0);

        // 1. msg=2, key=1 on the 2-round build with L=5
        b0  = bq2.size();
        nd0 = ndone2;
        pulse_start(0, 254'd2, 254'd1);
        wait_done(0, 100, dcyc, bb);
        chk("t1_done_cycle", dcyc, 16);
        chk("t1_busy_holes", bb, 0);
        chk("t1_hash", hash2, 254'd29792);
        chk("t1_n_launch", bq2.size() - b0, 2);
        chk("t1_base0", bq2[b0], 254'd3);
        chk("t1_base1", bq2[b0+1], 254'd31);
        // start on the done cycle must be dropped
        msg    = 254'd7;
        key    = 254'd7;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("t1_done_width", done2, 0);
        chk("t1_busy_after_done", busy2, 0);
        @(negedge clk);
        chk("t1_start_on_done_ignored", busy2, 0);
        chk("t1_hash_held", hash2, 254'd29792);
        chk("t1_done_count", ndone2 - nd0, 1);

        // 2. start while busy is ignored; then a fresh job
        pulse_start(0, 254'd2, 254'd1);
        repeat (4) @(negedge clk);
        pulse_start(0, 254'd5, 254'd9);
        wait_done(0, 100, dcyc, bb);
        chk("t2_hash_busy_start", hash2, 254'd29792);
        pulse_start(0, 254'd0, 254'd0);
        wait_done(0, 100, dcyc, bb);
        chk("t2_hash_zero", hash2, 254'd27);

        // 3. single round, wrap paths of both adders
        rom1 = '0;
        b0 = bq1.size();
        pulse_start(1, P - 254'd1, 254'd1);
        wait_done(1, 100, dcyc, bb);
        chk("t3a_done_cycle", dcyc, 7);
        chk("t3a_base", bq1[b0], 0);
        chk("t3a_hash", hash1, 254'd1);
        rom1 = P - 254'd1;
        b0 = bq1.size();
        pulse_start(1, P - 254'd1, P - 254'd1);
        wait_done(1, 100, dcyc, bb);
        chk("t3b_base", bq1[b0], P - 254'd3);
        chk("t3b_hash", hash1, P - 254'd28);

        // 4. reset in WAIT_POW of round 0 aborts at once
        pulse_start(0, 254'd2, 254'd1);
        repeat (2) @(negedge clk);
        chk("t4_in_wait_pow", pow_en2, 1);
        nd0 = ndone2;
        rst = 1'b0;
        #1;
        chk("t4_pow_en_async", pow_en2, 0);
        chk("t4_busy_async", busy2, 0);
        chk("t4_hash_async", hash2, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_no_done", ndone2 - nd0, 0);
        chk("t4_idle_after", busy2, 0);
        pulse_start(0, 254'd2, 254'd1);
        wait_done(0, 100, dcyc, bb);
        chk("t4_hash_after", hash2, 254'd29792);

        // 5. full 91-round jobs against the model; first job is msg=key=0
        for (int r = 0; r < 5; r++) begin
            m     = (r == 0) ? '0 : rand_fe();
            k     = (r == 0) ? '0 : rand_fe();
            lat91 = $urandom_range(1, 4);
            model(m, k, rom91, h_exp);
            @(negedge clk);
            base91 = bq91.size();
            n0     = addr_err91;
            pulse_start(2, m, k);
            if (r == 1) begin
                repeat (10) @(negedge clk);
                pulse_start(2, rand_fe(), rand_fe());
            end
            wait_done(2, 1000, dcyc, bb);
            if (r != 1) chk($sformatf("t5_done_cycle_r%0d", r), dcyc, 91 * (2 + lat91) + 2);
            chk($sformatf("t5_hash_r%0d", r), hash91, h_exp);
            chk($sformatf("t5_n_launch_r%0d", r), bq91.size() - base91, 91);
            berr = 0;
            for (int i = 0; i < 91; i++)
                if (base91 + i >= bq91.size() || bq91[base91 + i] !== exp_base[i]) berr++;
            chk($sformatf("t5_bases_r%0d", r), berr, 0);
            @(negedge clk);
            chk($sformatf("t5_rc_addr_sweep_r%0d", r), addr_err91 - n0, 0);
            chk($sformatf("t5_idle_r%0d", r), busy91, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
